main_memory_ctrl: RTL and testbench

Sequencing controller and 3-way arbiter in front of main_memory (15-bit line/byte address, 256-bit data, byte write mask selected by WRITE_SIZE).
- Shares the single memory port between the instruction cache (IC, SRC=0), data cache (DC, SRC=1) and DMA engine (DMA, SRC=2).
- Uses round-robin arbitration.
- Drives address, write strobe and write data through a fixed setup/access/hold sequence, and returns read data with a per-requester ACK pulse.

---
 rtl/main_memory_pkg.sv | 25 ++
 rtl/main_memory_ctrl_if.sv | 61 ++++++
 rtl/rr_arbiter3.sv | 40 ++++
 rtl/main_memory_ctrl.sv | 139 +++++++++++++
 tb/tb_main_memory_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_pkg.sv
// Shared types and constants for the main memory controller.
//   SRC_*   : requester identifiers as seen on OWNER and in the arbiter.
//   state_e : controller sequencing states.
//   rr_next : round-robin successor of a requester index (3 wraps like 2).
package main_memory_pkg;

  localparam logic [1:0] SRC_IC   = 2'd0;
  localparam logic [1:0] SRC_DC   = 2'd1;
  localparam logic [1:0] SRC_DMA  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Successor in the IC -> DC -> DMA -> IC ring. An out-of-range index
  // behaves like DMA so the scan always restarts at IC.
  function automatic logic [1:0] rr_next(input logic [1:0] cur);
    return (cur >= SRC_DMA) ? SRC_IC : cur + 2'd1;
  endfunction

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Bus bundle between the three requesters / main_memory and the controller.
//   Requester side : *_REQ, *_WR, *_ADDR, *_SIZE, *_WDATA in, *_ACK out.
//   Shared status  : RD_DATA, OWNER, BUSY.
//   Memory side    : MEM_ADDR, MEM_EN, MEM_WR, MEM_WRITE_SIZE, MEM_DATA_OUT,
//                    MEM_DATA_OE out, MEM_DATA_IN in.
// Handshake: a requester raises REQ (level) with stable operands and keeps
// both until its ACK pulse; ACK is high for exactly one cycle and RD_DATA is
// valid in that cycle. REQ still high in the cycle after ACK is a new request.
// modport slave is the controller view, modport master the requester/memory view.
interface main_memory_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 256
);
  logic              IC_REQ;
  logic [ADDR_W-1:0] IC_ADDR;
  logic              IC_ACK;

  logic              DC_REQ;
  logic              DC_WR;
  logic [ADDR_W-1:0] DC_ADDR;
  logic [2:0]        DC_SIZE;
  logic [DATA_W-1:0] DC_WDATA;
  logic              DC_ACK;

  logic              DMA_REQ;
  logic              DMA_WR;
  logic [ADDR_W-1:0] DMA_ADDR;
  logic [2:0]        DMA_SIZE;
  logic [DATA_W-1:0] DMA_WDATA;
  logic              DMA_ACK;

  logic [DATA_W-1:0] RD_DATA;
  logic [1:0]        OWNER;
  logic              BUSY;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_EN;
  logic              MEM_WR;
  logic [2:0]        MEM_WRITE_SIZE;
  logic [DATA_W-1:0] MEM_DATA_OUT;
  logic              MEM_DATA_OE;
  logic [DATA_W-1:0] MEM_DATA_IN;

  modport slave (
    input  IC_REQ, IC_ADDR,
    input  DC_REQ, DC_WR, DC_ADDR, DC_SIZE, DC_WDATA,
    input  DMA_REQ, DMA_WR, DMA_ADDR, DMA_SIZE, DMA_WDATA,
    input  MEM_DATA_IN,
    output IC_ACK, DC_ACK, DMA_ACK, RD_DATA, OWNER, BUSY,
    output MEM_ADDR, MEM_EN, MEM_WR, MEM_WRITE_SIZE, MEM_DATA_OUT, MEM_DATA_OE
  );

  modport master (
    output IC_REQ, IC_ADDR,
    output DC_REQ, DC_WR, DC_ADDR, DC_SIZE, DC_WDATA,
    output DMA_REQ, DMA_WR, DMA_ADDR, DMA_SIZE, DMA_WDATA,
    output MEM_DATA_IN,
    input  IC_ACK, DC_ACK, DMA_ACK, RD_DATA, OWNER, BUSY,
    input  MEM_ADDR, MEM_EN, MEM_WR, MEM_WRITE_SIZE, MEM_DATA_OUT, MEM_DATA_OE
  );
endinterface

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter.
//   req_i[2:0]    : request per source (bit 0 IC, bit 1 DC, bit 2 DMA).
//   last_i[1:0]   : most recently granted source.
//   grant_valid_o : some request is present.
//   grant_o[1:0]  : winning source, SRC_NONE when nothing requests.
// The scan starts just after last_i, so the last winner has lowest priority.
module rr_arbiter3
  import main_memory_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic       grant_valid_o,
  output logic [1:0] grant_o
);

  logic [3:0] req_ext;
  logic [1:0] cand0, cand1, cand2;

  // Padding to four entries lets the 2-bit candidates index safely.
  assign req_ext = {1'b0, req_i};
  assign cand0   = rr_next(last_i);
  assign cand1   = rr_next(cand0);
  assign cand2   = rr_next(cand1);

  always_comb begin
    grant_valid_o = 1'b0;
    grant_o       = SRC_NONE;
    if (req_ext[cand0]) begin
      grant_valid_o = 1'b1;
      grant_o       = cand0;
    end else if (req_ext[cand1]) begin
      grant_valid_o = 1'b1;
      grant_o       = cand1;
    end else if (req_ext[cand2]) begin
      grant_valid_o = 1'b1;
      grant_o       = cand2;
    end
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Sequencing controller and round-robin arbiter in front of main_memory.
//   CLK         : system clock, all state on rising edge.
//   CLR         : asynchronous active-low reset.
//   bus         : requester, status and memory signals (main_memory_ctrl_if.slave).
//   dbg_state_o : current sequencing state.
// Each transaction runs IDLE -> SETUP -> ACCESS x MEM_LATENCY -> HOLD -> IDLE.
// Operands are latched at the grant, so requesters may change them afterwards.
module main_memory_ctrl
  import main_memory_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 256
) (
  input  logic               CLK,
  input  logic               CLR,
  main_memory_ctrl_if.slave  bus,
  output state_e             dbg_state_o
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              grant_valid;
  logic [1:0]        grant;

  rr_arbiter3 u_arb (
    .req_i         ({bus.DMA_REQ, bus.DC_REQ, bus.IC_REQ}),
    .last_i        (last_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= SRC_DMA;
      owner_q   <= SRC_NONE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_SETUP;
          last_d  = grant;
          owner_d = grant;
          case (grant)
            SRC_IC: begin
              addr_d  = bus.IC_ADDR;
              wr_d    = 1'b0;
              size_d  = 3'd0;
              wdata_d = '0;
            end
            SRC_DC: begin
              addr_d  = bus.DC_ADDR;
              wr_d    = bus.DC_WR;
              size_d  = bus.DC_SIZE;
              wdata_d = bus.DC_WDATA;
            end
            default: begin
              addr_d  = bus.DMA_ADDR;
              wr_d    = bus.DMA_WR;
              size_d  = bus.DMA_SIZE;
              wdata_d = bus.DMA_WDATA;
            end
          endcase
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          // Last access cycle: the memory output is stable, capture reads.
          if (!wr_q) rd_data_d = bus.MEM_DATA_IN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state_q so the asynchronous reset removes
  // them at once, without waiting for a clock edge.
  assign bus.BUSY           = (state_q != ST_IDLE);
  assign bus.OWNER          = bus.BUSY ? owner_q : SRC_NONE;
  assign bus.MEM_EN         = bus.BUSY;
  assign bus.MEM_WR         = (state_q == ST_ACCESS) && wr_q;
  assign bus.MEM_DATA_OE    = bus.BUSY && wr_q;
  assign bus.MEM_ADDR       = addr_q;
  assign bus.MEM_WRITE_SIZE = size_q;
  assign bus.MEM_DATA_OUT   = wdata_q;
  assign bus.RD_DATA        = rd_data_q;
  assign bus.IC_ACK         = (state_q == ST_HOLD) && (owner_q == SRC_IC);
  assign bus.DC_ACK         = (state_q == ST_HOLD) && (owner_q == SRC_DC);
  assign bus.DMA_ACK        = (state_q == ST_HOLD) && (owner_q == SRC_DMA);
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: one instance at MEM_LATENCY=4
// with a scoreboard monitor, and one at MEM_LATENCY=1 for directed checks.
module tb_main_memory_ctrl;
  import main_memory_pkg::*;

  localparam int AW  = 15;
  localparam int DW  = 256;
  localparam int LAT = 4;
  localparam int CW  = AW + 3 + DW;
  localparam int SBW = 2 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic CLR;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  main_memory_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  main_memory_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  state_e dbg_state, dbg_state1;

  main_memory_ctrl #(.MEM_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .CLK(CLK), .CLR(CLR), .bus(bus.slave), .dbg_state_o(dbg_state)
  );
  main_memory_ctrl #(.MEM_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .bus(bus1.slave), .dbg_state_o(dbg_state1)
  );

  // Memory model: read data is an address-dependent A5 pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {32{8'hA5}} ^ {16{1'b0, a}};
  endfunction
  assign bus.MEM_DATA_IN  = pat(bus.MEM_ADDR);
  assign bus1.MEM_DATA_IN = pat(bus1.MEM_ADDR);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  logic [DW-1:0]  sb_last_rd = '0;

  // Entries are pushed in grant order; a write expects RD_DATA untouched.
  task automatic push_exp(input logic [1:0] src, input logic wr, input logic [AW-1:0] addr);
    if (!wr) sb_last_rd = pat(addr);
    exp_q.push_back({src, ~wr, sb_last_rd});
  endtask

  always @(negedge CLK) begin : mon
    logic [1:0]     s;
    logic [SBW-1:0] e;
    if (bus.IC_ACK || bus.DC_ACK || bus.DMA_ACK) begin
      check("ack_onehot", CW'($countones({bus.IC_ACK, bus.DC_ACK, bus.DMA_ACK})), CW'(1));
      s = bus.IC_ACK ? SRC_IC : (bus.DC_ACK ? SRC_DC : SRC_DMA);
      check("owner_at_ack", CW'(bus.OWNER), CW'(s));
      check("ack_expected", CW'(exp_q.size() > 0), CW'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_result", CW'({s, ~bus.MEM_DATA_OE, bus.RD_DATA}), CW'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic ack_of(input logic [1:0] src);
    case (src)
      SRC_IC:  return bus.IC_ACK;
      SRC_DC:  return bus.DC_ACK;
      default: return bus.DMA_ACK;
    endcase
  endfunction

  task automatic set_req(input logic [1:0] src, input logic req, input logic wr,
                         input logic [AW-1:0] addr, input logic [2:0] size,
                         input logic [DW-1:0] wd);
    case (src)
      SRC_IC: begin
        bus.IC_REQ = req; bus.IC_ADDR = addr;
      end
      SRC_DC: begin
        bus.DC_REQ = req; bus.DC_WR = wr; bus.DC_ADDR = addr;
        bus.DC_SIZE = size; bus.DC_WDATA = wd;
      end
      default: begin
        bus.DMA_REQ = req; bus.DMA_WR = wr; bus.DMA_ADDR = addr;
        bus.DMA_SIZE = size; bus.DMA_WDATA = wd;
      end
    endcase
  endtask

  // Counts edges from the request-sampling edge until the ACK is seen,
  // and records strobe activity and the SETUP-cycle bus snapshot.
  task automatic wait_ack(input logic [1:0] src, output int lat, output int wrc,
                          output int oec, output logic [CW-1:0] snap);
    logic done;
    done = 1'b0; lat = 0; wrc = 0; oec = 0; snap = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (bus.MEM_WR) wrc++;
      if (bus.MEM_DATA_OE) oec++;
      if (lat == 1) snap = {bus.MEM_ADDR, bus.MEM_WRITE_SIZE, bus.MEM_DATA_OUT};
      if (ack_of(src)) done = 1'b1;
    end
    check("ack_seen", CW'(done), CW'(1));
  endtask

  task automatic run_req(input logic [1:0] src, input logic wr, input logic [AW-1:0] addr,
                         input logic [2:0] size, input logic [DW-1:0] wd,
                         output int lat, output int wrc, output int oec,
                         output logic [CW-1:0] snap);
    set_req(src, 1'b1, wr, addr, size, wd);
    push_exp(src, wr, addr);
    wait_ack(src, lat, wrc, oec, snap);
    @(posedge CLK);
    #1 set_req(src, 1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
  endtask

  // DMA on the latency-1 instance; REQ dropped and operands scrambled in SETUP.
  task automatic run_dma1(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output int lat, output int wrc);
    logic done;
    bus1.DMA_WR = wr; bus1.DMA_ADDR = addr; bus1.DMA_SIZE = 3'b101;
    bus1.DMA_WDATA = wd; bus1.DMA_REQ = 1'b1;
    done = 1'b0; lat = 0; wrc = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge CLK);
      lat++;
      if (lat == 1) begin
        #1;
        bus1.DMA_REQ = 1'b0; bus1.DMA_ADDR = ~addr; bus1.DMA_WR = ~wr;
      end
      @(negedge CLK);
      if (bus1.MEM_WR) wrc++;
      if (bus1.DMA_ACK) done = 1'b1;
    end
    check("dma1_ack_seen", CW'(done), CW'(1));
    @(posedge CLK);
    #1;
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat, wrc, oec;
    logic [CW-1:0] snap;
    logic all_dropped;

    CLR = 1'b0;
    set_req(SRC_IC, 0, 0, '0, '0, '0);
    set_req(SRC_DC, 0, 0, '0, '0, '0);
    set_req(SRC_DMA, 0, 0, '0, '0, '0);
    bus1.IC_REQ = 0; bus1.IC_ADDR = '0;
    bus1.DC_REQ = 0; bus1.DC_WR = 0; bus1.DC_ADDR = '0; bus1.DC_SIZE = '0; bus1.DC_WDATA = '0;
    bus1.DMA_REQ = 0; bus1.DMA_WR = 0; bus1.DMA_ADDR = '0; bus1.DMA_SIZE = '0; bus1.DMA_WDATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);

    // Reset state
    check("rst_owner", CW'(bus.OWNER), CW'(SRC_NONE));
    check("rst_busy_en_wr_oe", CW'({bus.BUSY, bus.MEM_EN, bus.MEM_WR, bus.MEM_DATA_OE}), CW'(0));
    check("rst_acks", CW'({bus.IC_ACK, bus.DC_ACK, bus.DMA_ACK}), CW'(0));
    check("rst_rd_data", CW'(bus.RD_DATA), CW'(0));
    check("rst_mem_addr", CW'(bus.MEM_ADDR), CW'(0));
    CLR = 1'b1;
    @(negedge CLK);

    // 1. IC read
    run_req(SRC_IC, 1'b0, 15'h0123, 3'd0, '0, lat, wrc, oec, snap);
    check("t1_latency", CW'(lat), CW'(LAT + 2));
    check("t1_wr_cycles", CW'(wrc), CW'(0));
    check("t1_oe_cycles", CW'(oec), CW'(0));
    check("t1_setup_addr", CW'(snap[CW-1 -: AW]), CW'(15'h0123));

    // 2. DC write then DMA read of the same line
    run_req(SRC_DC, 1'b1, 15'h1F40, 3'b010, 256'hDEADBEEF, lat, wrc, oec, snap);
    check("t2_wr_latency", CW'(lat), CW'(LAT + 2));
    check("t2_wr_cycles", CW'(wrc), CW'(LAT));
    check("t2_oe_cycles", CW'(oec), CW'(LAT + 2));
    check("t2_setup_bus", snap, {15'h1F40, 3'b010, 256'hDEADBEEF});
    run_req(SRC_DMA, 1'b0, 15'h1F40, 3'd0, '0, lat, wrc, oec, snap);
    check("t2_rd_latency", CW'(lat), CW'(LAT + 2));
    check("t2_rd_wr_cycles", CW'(wrc), CW'(0));

    // 3. All three requesting continuously: grants rotate IC, DC, DMA
    set_req(SRC_IC, 1, 0, 15'h0100, 3'd0, '0);
    set_req(SRC_DC, 1, 0, 15'h0200, 3'd0, '0);
    set_req(SRC_DMA, 1, 0, 15'h0300, 3'd0, '0);
    for (int r = 0; r < 2; r++) begin
      push_exp(SRC_IC, 0, 15'h0100);
      push_exp(SRC_DC, 0, 15'h0200);
      push_exp(SRC_DMA, 0, 15'h0300);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    check("t3_all_acked", CW'(exp_q.size()), CW'(0));
    set_req(SRC_IC, 0, 0, '0, '0, '0);
    set_req(SRC_DC, 0, 0, '0, '0, '0);
    set_req(SRC_DMA, 0, 0, '0, '0, '0);
    @(posedge CLK);
    #1;
    @(negedge CLK);

    // 4. Reset in the 2nd ACCESS cycle of a DC write
    set_req(SRC_DC, 1, 1, 15'h0055, 3'b011, {8{32'hCAFEF00D}});
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #1 check("t4_pre_wr", CW'(bus.MEM_WR), CW'(1));
    #1 CLR = 1'b0;
    #1;
    check("t4_wr_oe_en", CW'({bus.MEM_WR, bus.MEM_DATA_OE, bus.MEM_EN}), CW'(0));
    check("t4_dc_ack", CW'(bus.DC_ACK), CW'(0));
    check("t4_owner", CW'(bus.OWNER), CW'(SRC_NONE));
    set_req(SRC_DC, 0, 0, '0, '0, '0);
    exp_q.delete();
    sb_last_rd = '0;
    @(negedge CLK);
    check("t4_rd_data_cleared", CW'(bus.RD_DATA), CW'(0));
    CLR = 1'b1;
    @(negedge CLK);
    set_req(SRC_IC, 1, 0, 15'h0C0C, 3'd0, '0);
    set_req(SRC_DC, 1, 0, 15'h0D0D, 3'd0, '0);
    set_req(SRC_DMA, 1, 0, 15'h0E0E, 3'd0, '0);
    push_exp(SRC_IC, 0, 15'h0C0C);
    push_exp(SRC_DC, 0, 15'h0D0D);
    push_exp(SRC_DMA, 0, 15'h0E0E);
    @(negedge CLK);
    check("t4_first_grant", CW'(bus.OWNER), CW'(SRC_IC));
    all_dropped = 1'b0;
    for (int i = 0; i < 100 && !all_dropped; i++) begin
      @(negedge CLK);
      if (bus.IC_ACK) set_req(SRC_IC, 0, 0, '0, '0, '0);
      if (bus.DC_ACK) set_req(SRC_DC, 0, 0, '0, '0, '0);
      if (bus.DMA_ACK) set_req(SRC_DMA, 0, 0, '0, '0, '0);
      all_dropped = !(bus.IC_REQ || bus.DC_REQ || bus.DMA_REQ);
    end
    check("t4_all_served", CW'(all_dropped), CW'(1));
    @(posedge CLK);
    #1;
    @(negedge CLK);

    // 6. DC keeps REQ one cycle past ACK: a second identical transaction
    set_req(SRC_DC, 1, 0, 15'h0ABC, 3'd0, '0);
    push_exp(SRC_DC, 0, 15'h0ABC);
    push_exp(SRC_DC, 0, 15'h0ABC);
    wait_ack(SRC_DC, lat, wrc, oec, snap);
    check("t6_first_latency", CW'(lat), CW'(LAT + 2));
    @(posedge CLK);
    @(posedge CLK);
    #1 set_req(SRC_DC, 0, 0, 15'h7FFF, 3'd0, '0);
    @(negedge CLK);
    check("t6_rereq_state", CW'(dbg_state), CW'(ST_SETUP));
    check("t6_rereq_owner", CW'(bus.OWNER), CW'(SRC_DC));
    check("t6_rereq_addr", CW'(bus.MEM_ADDR), CW'(15'h0ABC));
    wait_ack(SRC_DC, lat, wrc, oec, snap);
    @(posedge CLK);
    #1;
    @(negedge CLK);

    // 5. MEM_LATENCY=1 instance, DMA with REQ dropped in SETUP
    run_dma1(1'b0, 15'h0777, '0, lat, wrc);
    check("t5_rd_latency", CW'(lat), CW'(3));
    check("t5_rd_wr_cycles", CW'(wrc), CW'(0));
    check("t5_rd_data", CW'(bus1.RD_DATA), CW'(pat(15'h0777)));
    run_dma1(1'b1, 15'h0321, 256'h1234, lat, wrc);
    check("t5_wr_latency", CW'(lat), CW'(3));
    check("t5_wr_cycles", CW'(wrc), CW'(1));
    check("t5_rd_data_kept", CW'(bus1.RD_DATA), CW'(pat(15'h0777)));
    check("t5_idle_after", CW'(dbg_state1), CW'(ST_IDLE));

    repeat (10) @(negedge CLK);
    check("sb_empty", CW'(exp_q.size()), CW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
